// File: rtl/mbist_mem_clkgen.sv
// MBIST memory-under-test: 1-bit RAM with injectable CFid fault plus two divided clocks.
// Define LOPOW_CLKGEN_EN to build the clk_1/clk_2 dividers; otherwise both outputs are tied to 0.
module mbist_mem_clkgen #(
  parameter int unsigned ADDR          = 6,
  parameter int unsigned CFID_AGGR     = 5,
  parameter int unsigned CFID_VICT     = 4,
  parameter int unsigned CFID_VAL      = 0,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned C1_DUTY_NUM   = 3,
  parameter int unsigned C2_DUTY_CYCLE = 375
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            we,
  input  logic            oe,
  input  logic            cfid_en,
  input  logic [ADDR-1:0] addr,
  input  logic            d_in,
  output logic            d_out,
  output logic            clk_1,
  output logic            clk_2
);

  localparam int unsigned DEPTH = 2 ** ADDR;
  localparam logic [ADDR-1:0] AGGR = ADDR'(CFID_AGGR);
  localparam logic [ADDR-1:0] VICT = ADDR'(CFID_VICT);
  localparam logic            VAL  = 1'(CFID_VAL);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (cs && we) begin
      mem[addr] <= d_in;
      // Rising write on the aggressor disturbs the victim; this later assignment wins.
      if (cfid_en && (addr == AGGR) && !mem[addr] && d_in) begin
        mem[VICT] <= VAL;
      end
    end
  end

  assign d_out = (cs && oe) ? mem[addr] : 1'b0;

`ifdef LOPOW_CLKGEN_EN
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned H1 = 2 * C1_DUTY_NUM;
  localparam int unsigned H2 = (2 * CLK_DIV * C2_DUTY_CYCLE) / 1000;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LIM1 = CW'(H1 / 2);
  localparam logic [CW-1:0] LIM2 = CW'(H2 / 2);
  localparam logic          ODD1 = (H1 % 2) == 1;
  localparam logic          ODD2 = (H2 % 2) == 1;

  logic [CW-1:0] cnt_q;
  logic          pos1_q, pos2_q, neg1_q, neg2_q;

  // pos_* covers whole clk cycles starting at the posedge where the counter equals k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos1_q <= 1'b0;
      pos2_q <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      pos1_q <= cnt_q < LIM1;
      pos2_q <= cnt_q < LIM2;
    end
  end

  // For odd H, extend the high phase by one half-cycle past the last pos_* cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
    end else begin
      neg1_q <= ODD1 && pos1_q;
      neg2_q <= ODD2 && pos2_q;
    end
  end

  assign clk_1 = pos1_q | neg1_q;
  assign clk_2 = pos2_q | neg2_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CLK_DIV, C1_DUTY_NUM, C2_DUTY_CYCLE};
  assign clk_1 = 1'b0;
  assign clk_2 = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_mem_clkgen.sv
// Self-checking bench for mbist_mem_clkgen: vector table, directed sequences, random vs. model.
module tb_mbist_mem_clkgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0, we = 1'b0, oe = 1'b0, cfid_en = 1'b0, d_in = 1'b0;
  logic [5:0] addr = '0;
  logic       d_out, clk_1, clk_2;

  int tests = 0;
  int fails = 0;
  bit model_mem [64];

  mbist_mem_clkgen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .we      (we),
    .oe      (oe),
    .cfid_en (cfid_en),
    .addr    (addr),
    .d_in    (d_in),
    .d_out   (d_out),
    .clk_1   (clk_1),
    .clk_2   (clk_2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       c, w, o, f;
    logic [5:0] a;
    logic       d;
    logic       exp;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model_mem[i] = 1'b0;
  endtask

  // One clk cycle: drive after negedge, check read before posedge, update model at posedge.
  task automatic step(input logic c, input logic w, input logic o, input logic f,
                      input logic [5:0] a, input logic d, output logic obs);
    logic old;
    @(negedge clk);
    cs = c; we = w; oe = o; cfid_en = f; addr = a; d_in = d;
    #1;
    obs = d_out;
    check("d_out_model", d_out, (c && o) ? model_mem[a] : 1'b0);
    @(posedge clk);
    if (c && w) begin
      old = model_mem[a];
      model_mem[a] = d;
      if (f && a == 6'd5 && !old && d) model_mem[4] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    cs = 1'b1; oe = 1'b1; we = 1'b1; d_in = 1'b1; addr = 6'd7;
    rst_n = 1'b0;
    #1;
    check("rst_clk_1", clk_1, 1'b0);
    check("rst_clk_2", clk_2, 1'b0);
    check("rst_d_out", d_out, 1'b0);
    @(posedge clk);
    #1;
    check("rst_clk_1_hold", clk_1, 1'b0);
    check("rst_d_out_hold", d_out, 1'b0);
    @(negedge clk);
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    rst_n = 1'b1;
    clear_model();
  endtask

  vec_t vecs [15];
  logic obs;
  int   h;
  logic e1, e2;

  initial begin
    // CFid sequence starting from an all-zero array.
    vecs[0]  = '{1, 1, 0, 1, 6'd4, 1, 0};
    vecs[1]  = '{1, 0, 1, 1, 6'd4, 0, 1};
    vecs[2]  = '{1, 1, 0, 1, 6'd5, 1, 0};
    vecs[3]  = '{1, 0, 1, 1, 6'd4, 0, 0};
    vecs[4]  = '{1, 0, 1, 1, 6'd5, 0, 1};
    vecs[5]  = '{1, 1, 0, 1, 6'd4, 1, 0};
    vecs[6]  = '{1, 1, 1, 1, 6'd5, 1, 1};
    vecs[7]  = '{1, 0, 1, 1, 6'd4, 0, 1};
    vecs[8]  = '{1, 1, 1, 1, 6'd5, 0, 1};
    vecs[9]  = '{1, 0, 1, 1, 6'd4, 0, 1};
    vecs[10] = '{1, 0, 1, 1, 6'd5, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 6'd5, 1, 0};
    vecs[12] = '{1, 0, 1, 0, 6'd4, 0, 1};
    vecs[13] = '{0, 0, 1, 0, 6'd4, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 6'd4, 0, 0};

    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 6'(i), 1, obs);
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 1, 0, 6'(i), 0, obs);
      check("post_reset_zero", obs, 1'b0);
    end

    // Divided clocks: half-cycle 0 starts at the first posedge after release.
    pulse_reset();
    for (h = 0; h < 24; h++) begin
      if (h % 2 == 0) @(posedge clk); else @(negedge clk);
      #2;
`ifdef LOPOW_CLKGEN_EN
      e1 = (h % 8) < 6;
      e2 = (h % 8) < 3;
`else
      e1 = 1'b0;
      e2 = 1'b0;
`endif
      check("clk_1_wave", clk_1, e1);
      check("clk_2_wave", clk_2, e2);
    end

    // Fault-free fill and read-back.
    for (int i = 0; i < 64; i++) step(1, 1, 0, 0, 6'(i), 0, obs);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 6'(i), 1, obs);
    for (int i = 0; i < 64; i++) begin
      step(1, 0, 1, 0, 6'(i), 0, obs);
      check("fill_read", obs, i < 20);
    end
    step(0, 0, 1, 0, 6'd3, 0, obs);
    check("cs_low", obs, 1'b0);
    step(1, 0, 0, 0, 6'd3, 0, obs);
    check("oe_low", obs, 1'b0);

    // R1 -> W0 in the same cycle returns the old value, then reads 0.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1, 0, 6'(i), 0, obs);
      check("rw_old_value", obs, 1'b1);
      step(1, 0, 1, 0, 6'(i), 0, obs);
      check("rw_new_value", obs, 1'b0);
    end

    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].c, vecs[i].w, vecs[i].o, vecs[i].f, vecs[i].a, vecs[i].d, obs);
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Random traffic biased towards the aggressor/victim pair.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(4, 5)) : 6'($urandom_range(0, 63));
      step(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom), ra, 1'($urandom), obs);
    end
    for (int i = 0; i < 64; i++) step(1, 0, 1, 0, 6'(i), 0, obs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
